// File: rtl/sa_pingpong_buf.sv
// Two-bank ping-pong buffer with valid/ready on both sides; the read pointer
// doubles as the select for a downstream 2:1 mux cell.
module sa_pingpong_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             mux_sel,
    output logic [1:0]       count
);
    logic [1:0][WIDTH-1:0] bank;
    logic [1:0]            full, full_nxt;
    logic                  wr_ptr, wr_ptr_nxt;
    logic                  rd_ptr, rd_ptr_nxt;
    logic                  push, pop;

    // Handshakes see only registered flags, so in_ready never depends on out_ready.
    assign push = in_valid & ~full[wr_ptr];
    assign pop  = out_ready & full[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            full   <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            full   <= full_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // With one word held, push and pop always address different banks.
    always_comb begin
        full_nxt   = full;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            full_nxt   = 2'b00;
            wr_ptr_nxt = 1'b0;
            rd_ptr_nxt = 1'b0;
        end else begin
            if (push) begin
                full_nxt[wr_ptr] = 1'b1;
                wr_ptr_nxt       = ~wr_ptr;
            end
            if (pop) begin
                full_nxt[rd_ptr] = 1'b0;
                rd_ptr_nxt       = ~rd_ptr;
            end
        end
    end

    always_comb begin
        in_ready  = ~full[wr_ptr];
        out_valid = full[rd_ptr];
        mux_sel   = rd_ptr;
        count     = {1'b0, full[0]} + {1'b0, full[1]};
        out_data  = bank[rd_ptr];
    end

    // Data registers carry no reset; a discarded push leaves them untouched.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset)
            bank[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_sa_pingpong_buf.sv
// Directed vector table, hand-written corner sequences and a randomized
// scoreboard run for sa_pingpong_buf.
module tb_sa_pingpong_buf;
    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, mux_sel;
    logic [31:0] out_data;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    sa_pingpong_buf #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mux_sel(mux_sel), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [31:0] din;
        logic [1:0]  e_cnt;
        logic        e_ir;
        logic        e_ov;
        logic        e_ms;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] c, input logic ir,
                             input logic ov, input logic ms);
        check({tag, ".count"}, {30'd0, count}, {30'd0, c});
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, ".mux_sel"}, {31'd0, mux_sel}, {31'd0, ms});
    endtask

    initial begin
        logic [31:0] q[$];
        logic        rdp, push, pop;

        vecs[0] = '{1'b0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'hA5A5A5A5, 2'd1, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5};
        vecs[2] = '{1'b1, 1'b0, 32'h5A5A5A5A, 2'd2, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5};
        vecs[3] = '{1'b1, 1'b0, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 1'b1, 32'h0,        2'd1, 1'b1, 1'b1, 1'b1, 32'h5A5A5A5A};
        vecs[5] = '{1'b0, 1'b1, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 1'b1, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        reset = 1'b0;
        check_ctl("reset", 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_ctl($sformatf("idle%0d", i), 2'd0, 1'b1, 1'b0, 1'b0);
        end

        // Fill, blocked push, single pop, drain, pop on empty
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].iv; out_ready = vecs[i].ordy; in_data = vecs[i].din;
            tick();
            check_ctl($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_ms);
            if (i > 0) check($sformatf("vec%0d.out_data", i), out_data, vecs[i].e_dat);
        end

        // Streaming at full rate from empty, both pointers at bank 0
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = k;
            tick();
            check_ctl($sformatf("stream%0d", k), 2'd1, 1'b1, 1'b1, k[0]);
            check($sformatf("stream%0d.out_data", k), out_data, k);
        end
        in_valid = 1'b0;
        tick();
        check_ctl("stream_drain", 2'd0, 1'b1, 1'b0, 1'b0);

        // Flush while full and pushing
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h33; tick();
        in_data = 32'h44; tick();
        check_ctl("pre_flush", 2'd2, 1'b0, 1'b1, 1'b0);
        flush = 1'b1; in_data = 32'h11; tick();
        flush = 1'b0;
        check_ctl("flush", 2'd0, 1'b1, 1'b0, 1'b0);
        in_data = 32'h22; tick();
        in_valid = 1'b0;
        check_ctl("post_flush", 2'd1, 1'b1, 1'b1, 1'b0);
        check("post_flush.out_data", out_data, 32'h22);

        // Reset mid-transfer with a push and pop in flight
        in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h77; tick();
        reset = 1'b1; in_data = 32'h88; tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_ctl("mid_reset", 2'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 32'h99; tick();
        in_valid = 1'b0;
        check_ctl("after_reset", 2'd1, 1'b1, 1'b1, 1'b0);
        check("after_reset.out_data", out_data, 32'h99);
        flush = 1'b1; tick(); flush = 1'b0;

        // Random traffic against a FIFO scoreboard
        q.delete();
        rdp = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            #1;
            if (c % 20 == 0 || bad < 5) begin
                check("rnd.count", {30'd0, count}, q.size());
                check("rnd.in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
                check("rnd.out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
                check("rnd.mux_sel", {31'd0, mux_sel}, {31'd0, rdp});
                if (q.size() > 0) check("rnd.out_data", out_data, q[0]);
            end
            push = in_valid && q.size() < 2;
            pop  = out_ready && q.size() > 0;
            tick();
            if (pop) begin
                void'(q.pop_front());
                rdp = ~rdp;
            end
            if (push) q.push_back(in_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
